dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 130 +++++++++++++
 tb/tb_dmem_responder.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Single-outstanding 32-bit word memory; response appears LATENCY edges after acceptance.
// req_ready is high only in IDLE; a response is held in RESP until resp_ready.
module dmem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [15:0] txn_count
);
  localparam int          AW         = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  CNT_INIT   = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;
  localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH_WORDS * 4);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_q;
  logic [3:0]      cnt_q;
  logic            we_q;
  logic            err_q;
  logic [AW-1:0]   idx_q;
  logic            resp_valid_q;
  logic            resp_err_q;
  logic [31:0]     resp_rdata_q;
  logic [15:0]     txn_q;
  logic [31:0]     mem_q [DEPTH_WORDS];

  logic [AW-1:0]   req_idx;
  logic            req_err;
  logic            accept;
  logic            sel_we;
  logic            sel_err;
  logic [AW-1:0]   sel_idx;
  logic [31:0]     rdata_d;

  assign req_idx = req_addr[AW+1:2];
  assign req_err = (req_addr[1:0] != 2'b00) || (req_addr >= ADDR_LIMIT);
  // rst_n gates acceptance so a write presented during reset cannot reach storage.
  assign accept  = rst_n && req_valid && (state_q == IDLE);

  // With LATENCY=1 the response is built straight from the live request.
  always_comb begin
    sel_we  = we_q;
    sel_err = err_q;
    sel_idx = idx_q;
    if (state_q == IDLE) begin
      sel_we  = req_we;
      sel_err = req_err;
      sel_idx = req_idx;
    end
    rdata_d = (sel_we || sel_err) ? 32'd0 : mem_q[sel_idx];
  end

  always_ff @(posedge clk) begin
    if (accept && req_we && !req_err) begin
      mem_q[req_idx] <= req_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      idx_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'd0;
      txn_q        <= 16'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q  <= req_we;
            err_q <= req_err;
            idx_q <= req_idx;
            if (LATENCY == 1) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= req_err;
              resp_rdata_q <= rdata_d;
            end else begin
              state_q <= WAIT;
              cnt_q   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= err_q;
            resp_rdata_q <= rdata_d;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            txn_q        <= txn_q + 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign txn_count  = txn_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed table, hold/reset sequences, random traffic vs a word-array model,
// latency checks on LATENCY=1/2/15 builds and a full txn_count wrap.
module tb_dmem_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_ready;

  logic        rdy0, rv0, err0, rdy1, rv1, err1, rdy15, rv15, err15;
  logic [31:0] rd0, rd1, rd15;
  logic [15:0] cnt0, cnt1, cnt15;

  dmem_responder #(.DEPTH_WORDS(64), .LATENCY(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy0), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rv0), .resp_ready(resp_ready),
    .resp_rdata(rd0), .resp_err(err0), .txn_count(cnt0));

  dmem_responder #(.DEPTH_WORDS(64), .LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy1), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rv1), .resp_ready(resp_ready),
    .resp_rdata(rd1), .resp_err(err1), .txn_count(cnt1));

  dmem_responder #(.DEPTH_WORDS(64), .LATENCY(15)) dut15 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy15), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rv15), .resp_ready(resp_ready),
    .resp_rdata(rd15), .resp_err(err15), .txn_count(cnt15));

  int          checks = 0;
  int          failures = 0;
  int          model_cnt = 0;
  logic [31:0] model_mem [64];
  bit          model_vld [64];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = 1'b0;
    resp_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_cnt = 0;
  endtask

  // Drives one request into the LATENCY=2 instance; lat counts edges from acceptance (inclusive).
  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wd, input int hold,
                        output logic [31:0] rd, output logic e, output int lat);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!rdy0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!rdy0) check("req_ready_wait", 32'(rdy0), 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rv0 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    repeat (hold) @(negedge clk);
    rd = rd0;
    e  = err0;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic run_and_check(input string nm, input logic we, input logic [31:0] addr,
                               input logic [31:0] wd, input int hold, input logic [31:0] exp_rd,
                               input logic exp_err, input bit chk_rd);
    logic [31:0] rd;
    logic        e;
    int          lat;
    do_txn(we, addr, wd, hold, rd, e, lat);
    check({nm, "_lat"}, lat, 32'd2);
    check({nm, "_err"}, 32'(e), 32'(exp_err));
    if (chk_rd) check({nm, "_rdata"}, rd, exp_rd);
    if (we && !exp_err) begin
      model_mem[addr[7:2]] = wd;
      model_vld[addr[7:2]] = 1'b1;
    end
    model_cnt++;
    check({nm, "_txn"}, 32'(cnt0), 32'(model_cnt[15:0]));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs [13];
    logic        we, exp_err;
    logic [31:0] addr, wd, exp_rd;
    bit          known;
    int          guard, l1, l2, l15, n, cyc;
    bit          seen;

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b0;
    for (int i = 0; i < 64; i++) model_vld[i] = 1'b0;

    // Reset values on all builds.
    repeat (2) @(negedge clk);
    check("rst_rv0", 32'(rv0), 0);  check("rst_rd0", rd0, 0);  check("rst_err0", 32'(err0), 0);
    check("rst_cnt0", 32'(cnt0), 0);
    check("rst_rv1", 32'(rv1), 0);  check("rst_rd1", rd1, 0);  check("rst_err1", 32'(err1), 0);
    check("rst_cnt1", 32'(cnt1), 0);
    check("rst_rv15", 32'(rv15), 0); check("rst_rd15", rd15, 0); check("rst_err15", 32'(err15), 0);
    check("rst_cnt15", 32'(cnt15), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_rdy0", 32'(rdy0), 1); check("rst_rdy1", 32'(rdy1), 1); check("rst_rdy15", 32'(rdy15), 1);

    // Directed table.
    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,          1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,          32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b0, 32'h0000_0012, 32'h0,          32'h0,          1'b1};
    vecs[3]  = '{1'b0, 32'h0000_0100, 32'h0,          32'h0,          1'b1};
    vecs[4]  = '{1'b1, 32'h0000_0000, 32'h1111_1111, 32'h0,          1'b0};
    vecs[5]  = '{1'b1, 32'h0000_0100, 32'h0BAD_BAD0, 32'h0,          1'b1};
    vecs[6]  = '{1'b0, 32'h0000_0000, 32'h0,          32'h1111_1111, 1'b0};
    vecs[7]  = '{1'b1, 32'h0000_00FC, 32'hCAFE_F00D, 32'h0,          1'b0};
    vecs[8]  = '{1'b0, 32'h0000_00FC, 32'h0,          32'hCAFE_F00D, 1'b0};
    vecs[9]  = '{1'b1, 32'h0000_0011, 32'h7777_7777, 32'h0,          1'b1};
    vecs[10] = '{1'b0, 32'h0000_0010, 32'h0,          32'hDEAD_BEEF, 1'b0};
    vecs[11] = '{1'b0, 32'hFFFF_FFFC, 32'h0,          32'h0,          1'b1};
    vecs[12] = '{1'b0, 32'h0000_0103, 32'h0,          32'h0,          1'b1};
    for (int i = 0; i < 13; i++)
      run_and_check($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata, 0,
                    vecs[i].exp_rd, vecs[i].exp_err, 1'b1);

    // Response held for 5 cycles with a competing request on the bus.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_wdata = 32'h0;
    @(posedge clk);
    @(negedge clk);
    req_we = 1'b1; req_wdata = 32'h5555_5555;
    guard = 0;
    while (!rv0 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    for (int i = 0; i < 5; i++) begin
      check($sformatf("hold%0d_rv", i), 32'(rv0), 1);
      check($sformatf("hold%0d_rd", i), rd0, 32'hDEAD_BEEF);
      check($sformatf("hold%0d_err", i), 32'(err0), 0);
      check($sformatf("hold%0d_rdy", i), 32'(rdy0), 0);
      check($sformatf("hold%0d_txn", i), 32'(cnt0), 32'(model_cnt[15:0]));
      @(negedge clk);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    model_cnt++;
    check("hold_rv_clear", 32'(rv0), 0);
    check("hold_txn", 32'(cnt0), 32'(model_cnt[15:0]));
    run_and_check("hold_reread", 1'b0, 32'h10, 32'h0, 0, 32'hDEAD_BEEF, 1'b0, 1'b1);

    // Random traffic against the word-array model.
    for (int i = 0; i < 300; i++) begin
      int sel;
      sel = $urandom_range(0, 9);
      we  = 1'($urandom_range(0, 1));
      wd  = $urandom;
      if (sel <= 6)      addr = 32'($urandom_range(0, 63)) * 4;
      else if (sel == 7) addr = 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(1, 3));
      else if (sel == 8) addr = 32'd256 + 32'($urandom_range(0, 1000)) * 4;
      else               addr = $urandom;
      exp_err = ((addr % 4) != 0) || (addr >= 256);
      known = 1'b1;
      exp_rd = 32'd0;
      if (!we && !exp_err) begin
        known  = model_vld[addr[7:2]];
        exp_rd = model_mem[addr[7:2]];
      end
      run_and_check($sformatf("rnd%0d", i), we, addr, wd, $urandom_range(0, 3), exp_rd, exp_err, known);
    end

    // Reset while a write waits in WAIT.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h04; req_wdata = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("wait_busy", 32'(rdy0), 0);
    rst_n = 1'b0;
    #1;
    check("wait_rst_rv", 32'(rv0), 0);
    check("wait_rst_cnt", 32'(cnt0), 0);
    check("wait_rst_rdy", 32'(rdy0), 1);
    @(posedge clk);
    #1;
    check("wait_rst_no_resp", 32'(rv0), 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_cnt = 0;
    model_mem[1] = 32'h1234_5678;
    model_vld[1] = 1'b1;
    run_and_check("wait_rst_read", 1'b0, 32'h04, 32'h0, 0, 32'h1234_5678, 1'b0, 1'b1);

    // Reset while a response is pending in RESP.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h04;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    guard = 0;
    while (!rv0 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check("resp_pre_rd", rd0, 32'h1234_5678);
    rst_n = 1'b0;
    #1;
    check("resp_rst_rv", 32'(rv0), 0);
    check("resp_rst_rd", rd0, 0);
    check("resp_rst_cnt", 32'(cnt0), 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_cnt = 0;

    // Latency of the three builds for one simultaneous read.
    do_reset();
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0; resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    l1 = 0; l2 = 0; l15 = 0;
    for (int e = 1; e <= 20; e++) begin
      if (rv1 && l1 == 0)   l1 = e;
      if (rv0 && l2 == 0)   l2 = e;
      if (rv15 && l15 == 0) l15 = e;
      @(negedge clk);
    end
    resp_ready = 1'b0;
    check("lat1", l1, 1);
    check("lat2", l2, 2);
    check("lat15", l15, 15);
    check("lat_txn1", 32'(cnt1), 1);
    check("lat_txn15", 32'(cnt15), 1);

    // 65536 back-to-back responses on the LATENCY=1 build.
    do_reset();
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0; resp_ready = 1'b1;
    n = 0; cyc = 0; seen = 1'b0;
    while (n < 65536 && cyc < 140000) begin
      @(negedge clk);
      cyc++;
      if (n == 65535 && !seen) begin
        check("wrap_ffff", 32'(cnt1), 32'h0000_FFFF);
        seen = 1'b1;
      end
      if (rv1) n++;
    end
    req_valid = 1'b0;
    @(negedge clk);
    resp_ready = 1'b0;
    check("wrap_count_reached", n, 65536);
    check("wrap_zero", 32'(cnt1), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
